// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT,
    FULL,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch responder: reads the word at pc_in, holds it for decode,
// and pulses pc_en when decode accepts it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        flush,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  addr_q;
  logic [31:0]  instr_q;
  logic         drop;

  logic capture, latch_addr, drop_set, drop_clr, fault_set, fault_clr, count_inc;
  logic misaligned;

  assign misaligned = (pc_in[1:0] != 2'b00);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    pc_en      = 1'b0;
    mem_read   = 1'b0;
    capture    = 1'b0;
    latch_addr = 1'b0;
    drop_set   = 1'b0;
    drop_clr   = 1'b0;
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
    count_inc  = 1'b0;

    unique case (state)
      IDLE: state_next = REQUEST;

      REQUEST: begin
        // A flush here simply restarts from the new pc_in; no bus request is issued.
        if (flush) begin
          state_next = REQUEST;
        end else if (misaligned) begin
          fault_set  = 1'b1;
          state_next = FAULT;
        end else begin
          mem_read   = 1'b1;
          latch_addr = 1'b1;
          if (mem_ack) begin
            capture    = 1'b1;
            state_next = FULL;
          end else begin
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        mem_read = 1'b1;
        if (mem_ack) begin
          drop_clr = 1'b1;
          if (drop || flush) begin
            state_next = REQUEST;
          end else begin
            capture    = 1'b1;
            state_next = FULL;
          end
        end else if (flush) begin
          drop_set = 1'b1;
        end
      end

      FULL: begin
        if (flush) begin
          state_next = REQUEST;
        end else if (decode_ready) begin
          pc_en      = 1'b1;
          count_inc  = 1'b1;
          state_next = REQUEST;
        end
      end

      FAULT: begin
        if (flush) begin
          fault_clr  = 1'b1;
          state_next = REQUEST;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      instr_q     <= '0;
      drop        <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      if (latch_addr) addr_q  <= pc_in;
      if (capture)    instr_q <= mem_rdata;
      if (drop_clr)      drop <= 1'b0;
      else if (drop_set) drop <= 1'b1;
      if (fault_clr)      fetch_fault <= 1'b0;
      else if (fault_set) fetch_fault <= 1'b1;
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

  // The address follows pc_in while requesting so a zero-wait ack sees the right address.
  assign mem_addr    = (state == REQUEST) ? pc_in : addr_q;
  assign instr_valid = (state == FULL);
  assign instr_out   = instr_valid ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue of expected fetched instructions.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        decode_ready;
  logic        flush;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_count = 0;
  logic [31:0] sb[$];

  fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .decode_ready(decode_ready),
    .flush       (flush),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check1 ({tag, "_mem_read"},    mem_read,    1'b0);
    check32({tag, "_mem_addr"},    mem_addr,    32'h0);
    check1 ({tag, "_pc_en"},       pc_en,       1'b0);
    check32({tag, "_instr_out"},   instr_out,   NOP);
    check1 ({tag, "_instr_valid"}, instr_valid, 1'b0);
    check1 ({tag, "_fetch_fault"}, fetch_fault, 1'b0);
    check32({tag, "_fetch_count"}, fetch_count, 32'h0);
  endtask

  // Decode accepts this cycle: instruction must match the oldest expected word.
  task automatic check_accept(input string tag);
    logic [31:0] exp;
    check1({tag, "_valid"}, instr_valid, 1'b1);
    check1({tag, "_pc_en"}, pc_en, 1'b1);
    check1({tag, "_no_read"}, mem_read, 1'b0);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end else begin
      exp = sb.pop_front();
      check32({tag, "_instr"}, instr_out, exp);
    end
    exp_count++;
  endtask

  task automatic check_held(input string tag);
    check1({tag, "_valid"}, instr_valid, 1'b1);
    check1({tag, "_pc_en"}, pc_en, 1'b0);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end else begin
      check32({tag, "_instr"}, instr_out, sb[0]);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    pc_in        = 32'h0;
    mem_ack      = 1'b1;
    mem_rdata    = 32'h1234_5678;
    decode_ready = 1'b1;
    flush        = 1'b0;

    // Reset with a spurious ack present
    repeat (3) @(negedge clock);
    #1;
    check_reset_values("reset");

    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b0;
    #1;
    check1("idle_no_read", mem_read, 1'b0);

    // Zero-wait fetch from 0x0
    @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    sb.push_back(32'h0050_0093);
    #1;
    check1 ("zw_read", mem_read, 1'b1);
    check32("zw_addr", mem_addr, 32'h0);
    check1 ("zw_pc_en", pc_en, 1'b0);

    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check_accept("zw_accept");

    // Three wait states at 0x40, decode stalled afterwards
    @(negedge clock);
    pc_in        = 32'h40;
    decode_ready = 1'b0;
    #1;
    check32("zw_count", fetch_count, 32'(exp_count));
    check1 ("zw_valid_drop", instr_valid, 1'b0);
    check32("zw_nop", instr_out, NOP);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A0_0113;
        sb.push_back(32'h00A0_0113);
      end
      #1;
      check1 ("ws_read", mem_read, 1'b1);
      check32("ws_addr", mem_addr, 32'h40);
      check1 ("ws_valid", instr_valid, 1'b0);
    end

    @(negedge clock);
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      check_held("stall");
    end

    @(negedge clock);
    decode_ready = 1'b1;
    #1;
    check_accept("stall_accept");

    // Flush while waiting; ack with DEADBEEF two cycles later must be discarded
    @(negedge clock);
    pc_in = 32'h80;
    #1;
    check1 ("fw_pc_en", pc_en, 1'b0);
    check32("fw_count", fetch_count, 32'(exp_count));
    check32("fw_addr_req", mem_addr, 32'h80);

    @(negedge clock);
    flush = 1'b1;
    #1;
    check1 ("fw_read_w1", mem_read, 1'b1);
    check32("fw_addr_w1", mem_addr, 32'h80);

    @(negedge clock);
    flush = 1'b0;
    pc_in = 32'h100;
    #1;
    check32("fw_addr_w2", mem_addr, 32'h80);

    @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check1("fw_ack_valid", instr_valid, 1'b0);

    @(negedge clock);
    mem_rdata = 32'h0020_0193;
    sb.push_back(32'h0020_0193);
    #1;
    check1 ("fw_refetch_valid", instr_valid, 1'b0);
    check32("fw_refetch_nop", instr_out, NOP);
    check1 ("fw_refetch_read", mem_read, 1'b1);
    check32("fw_refetch_addr", mem_addr, 32'h100);
    check32("fw_refetch_count", fetch_count, 32'(exp_count));

    // Flush together with decode_ready in FULL: flush wins
    @(negedge clock);
    mem_ack = 1'b0;
    flush   = 1'b1;
    #1;
    check1("ff_valid", instr_valid, 1'b1);
    check1("ff_pc_en", pc_en, 1'b0);
    void'(sb.pop_front());

    @(negedge clock);
    flush = 1'b0;
    #1;
    check32("ff_count", fetch_count, 32'(exp_count));
    check1 ("ff_valid_drop", instr_valid, 1'b0);

    // Flush in the same cycle as the ack: data discarded
    @(negedge clock);
    flush     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0001;
    #1;
    check1("fa_read", mem_read, 1'b1);

    // Misaligned pc_in
    @(negedge clock);
    flush   = 1'b0;
    mem_ack = 1'b0;
    pc_in   = 32'h2;
    #1;
    check1 ("mis_req_read", mem_read, 1'b0);
    check1 ("mis_req_valid", instr_valid, 1'b0);
    check32("mis_req_nop", instr_out, NOP);

    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      mem_ack = 1'b1;
      #1;
      check1 ("fault_flag", fetch_fault, 1'b1);
      check1 ("fault_read", mem_read, 1'b0);
      check1 ("fault_valid", instr_valid, 1'b0);
      check32("fault_nop", instr_out, NOP);
    end

    @(negedge clock);
    mem_ack = 1'b0;
    flush   = 1'b1;
    pc_in   = 32'h4;
    #1;
    check1("fault_flush_flag", fetch_fault, 1'b1);
    check1("fault_flush_read", mem_read, 1'b0);

    @(negedge clock);
    flush = 1'b0;
    #1;
    check1 ("recover_flag", fetch_fault, 1'b0);
    check1 ("recover_read", mem_read, 1'b1);
    check32("recover_addr", mem_addr, 32'h4);

    @(negedge clock);
    #1;
    check1 ("recover_wait_read", mem_read, 1'b1);
    check32("recover_wait_addr", mem_addr, 32'h4);

    // Asynchronous reset in the middle of WAIT
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    check_reset_values("midwait_reset");

    @(negedge clock);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFACE_0001;
    #1;
    check1("post_reset_idle_read", mem_read, 1'b0);
    check1("post_reset_idle_valid", instr_valid, 1'b0);

    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check1 ("post_reset_valid", instr_valid, 1'b0);
    check1 ("post_reset_read", mem_read, 1'b1);
    check32("post_reset_addr", mem_addr, 32'h4);
    check32("post_reset_count", fetch_count, 32'(exp_count));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
